// File: rtl/input_port_buffer_if.sv
// Handshake and data bundle between an upstream link, one input-port
// buffer, the switch allocator and the crossbar. The master side drives
// the inputs into the buffer (flits in, allocator grant); the slave side is
// the buffer itself.
interface input_port_buffer_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W+1:0] in_flit;
    logic              buffer_req;
    logic              buffer_grant;
    logic [2:0]        buffer_dport;
    logic [DATA_W+1:0] out_flit;
    logic              out_fire;
    logic              err;

    modport master (
        output in_valid, in_flit, buffer_grant,
        input  in_ready, buffer_req, buffer_dport, out_flit, out_fire, err
    );

    modport slave (
        input  in_valid, in_flit, buffer_grant,
        output in_ready, buffer_req, buffer_dport, out_flit, out_fire, err
    );
endinterface

// File: rtl/input_port_buffer.sv
// Router input-port flit buffer. Flits are queued in a small FIFO; when a
// head (or single) flit reaches the front, its XY route is latched and the
// buffer requests the switch allocator until the packet's tail has left.
// Non-head flits reaching the front with no packet open are discarded and
// flagged with a one-cycle error pulse.
module input_port_buffer #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 2,
    parameter int X_ADDR  = 0,
    parameter int Y_ADDR  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input_port_buffer_if.slave   io_port
);
    localparam int FLIT_W = DATA_W + 2;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [COORD_W-1:0] LP_X     = COORD_W'(X_ADDR);
    localparam logic [COORD_W-1:0] LP_Y     = COORD_W'(Y_ADDR);
    localparam logic [PTR_W:0]     LP_DEPTH = (PTR_W+1)'(DEPTH);

    // Bit 0 set marks a packet start, bit 1 set marks a packet end.
    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    logic [FLIT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    state_e             r_state;
    port_e              r_dport;
    logic               r_err;

    logic [FLIT_W-1:0]  w_head;
    flit_type_e         w_head_type;
    logic [COORD_W-1:0] w_dest_x;
    logic [COORD_W-1:0] w_dest_y;
    port_e              w_route;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_req;
    logic               w_fire;
    logic               w_drop;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_type = flit_type_e'(w_head[FLIT_W-1 -: 2]);
    assign w_dest_x    = w_head[COORD_W-1:0];
    assign w_dest_y    = w_head[2*COORD_W-1:COORD_W];

    assign w_empty = (r_count == '0);
    // At full a simultaneous pop does not open a slot in the same cycle.
    assign w_full  = (r_count == LP_DEPTH);
    assign w_push  = io_port.in_valid && !w_full;

    assign w_req   = (r_state == ST_ACTIVE) && !w_empty;
    assign w_fire  = w_req && io_port.buffer_grant;
    // A front flit that cannot start a packet while idle is an orphan.
    assign w_drop  = (r_state == ST_IDLE) && !w_empty && !w_head_type[0];
    assign w_pop   = w_fire || w_drop;

    assign io_port.in_ready     = !w_full;
    assign io_port.buffer_req   = w_req;
    assign io_port.buffer_dport = r_dport;
    assign io_port.out_flit     = w_head;
    assign io_port.out_fire     = w_fire;
    assign io_port.err          = r_err;

    // XY dimension-order route of the flit at the FIFO front.
    always_comb begin
        // NOTE: default first so every path assigns w_route and no latch is inferred.
        w_route = PORT_LOCAL;
        if (w_dest_x > LP_X) begin
            w_route = PORT_EAST;
        end else if (w_dest_x < LP_X) begin
            w_route = PORT_WEST;
        end else if (w_dest_y > LP_Y) begin
            w_route = PORT_NORTH;
        end else if (w_dest_y < LP_Y) begin
            w_route = PORT_SOUTH;
        end
    end

    // Flit storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy is tracked by the count, so stale entries are never read as valid.
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_port.in_flit;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Packet state machine: route latch on head, release on tail departure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_dport <= PORT_LOCAL;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_drop;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && w_head_type[0]) begin
                        r_dport <= w_route;
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_fire && w_head_type[1]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at router (1,1), DEPTH 4.
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge.
module tb_input_port_buffer;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;

    input_port_buffer_if #(.DATA_W(32)) bus ();

    input_port_buffer #(
        .DATA_W (32),
        .DEPTH  (4),
        .COORD_W(2),
        .X_ADDR (1),
        .Y_ADDR (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_port(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Flit = {type, 20'h0, tag, dest_y, dest_x}.
    function automatic logic [33:0] mk(input logic [1:0] t, input logic [7:0] tag,
                                       input logic [1:0] x, input logic [1:0] y);
        return {t, 20'h0, tag, y, x};
    endfunction

    logic [33:0] f2 [4];
    logic [33:0] f3 [5];
    logic [33:0] f4 [4];
    logic [33:0] s1;
    logic [33:0] s50;

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_flit      = '0;
        bus.buffer_grant = 1'b0;
        rst              = 1'b0;
        #3;
        check("rst_req",      64'(bus.buffer_req),   64'd0);
        check("rst_dport",    64'(bus.buffer_dport), 64'd0);
        check("rst_err",      64'(bus.err),          64'd0);
        check("rst_in_ready", 64'(bus.in_ready),     64'd1);
        check("rst_fire",     64'(bus.out_fire),     64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        adv();

        // SINGLE to (3,1): EAST, req two cycles after the push edge.
        s1 = mk(T_SINGLE, 8'd1, 2'd3, 2'd1);
        bus.in_valid = 1'b1;
        bus.in_flit  = s1;
        mid();
        check("t1_ready", 64'(bus.in_ready), 64'd1);
        check("t1_req0",  64'(bus.buffer_req), 64'd0);
        adv();
        bus.in_valid = 1'b0;
        mid();
        check("t1_req1",  64'(bus.buffer_req), 64'd0);
        check("t1_head",  64'(bus.out_flit),   64'(s1));
        adv();
        bus.buffer_grant = 1'b1;
        mid();
        check("t1_req2",  64'(bus.buffer_req),   64'd1);
        check("t1_dport", 64'(bus.buffer_dport), 64'd2);
        check("t1_fire",  64'(bus.out_fire),     64'd1);
        adv();
        bus.buffer_grant = 1'b0;
        mid();
        check("t1_idle_req", 64'(bus.buffer_req), 64'd0);
        adv();

        // HEAD (1,0) + 2 BODY + TAIL, grant held high: SOUTH, fires in cycles 2..5.
        f2[0] = mk(T_HEAD, 8'd2, 2'd1, 2'd0);
        f2[1] = mk(T_BODY, 8'd3, 2'd0, 2'd0);
        f2[2] = mk(T_BODY, 8'd4, 2'd0, 2'd0);
        f2[3] = mk(T_TAIL, 8'd5, 2'd0, 2'd0);
        bus.buffer_grant = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bus.in_valid = (c < 4);
            if (c < 4) bus.in_flit = f2[c];
            mid();
            check($sformatf("t2_fire_c%0d", c), 64'(bus.out_fire), 64'((c >= 2) && (c <= 5)));
            if (c >= 2 && c <= 5) begin
                check($sformatf("t2_flit_c%0d", c), 64'(bus.out_flit), 64'(f2[c-2]));
                check($sformatf("t2_dport_c%0d", c), 64'(bus.buffer_dport), 64'd3);
            end
            if (c == 6) check("t2_req_after_tail", 64'(bus.buffer_req), 64'd0);
            adv();
        end
        bus.in_valid     = 1'b0;
        bus.buffer_grant = 1'b0;

        // Fill to full with grant low; grant at full pops without admitting the push.
        f3[0] = mk(T_HEAD, 8'd10, 2'd0, 2'd1);
        f3[1] = mk(T_BODY, 8'd11, 2'd0, 2'd0);
        f3[2] = mk(T_BODY, 8'd12, 2'd0, 2'd0);
        f3[3] = mk(T_BODY, 8'd13, 2'd0, 2'd0);
        f3[4] = mk(T_TAIL, 8'd14, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_flit  = f3[i];
            mid();
            check($sformatf("t3_ready_%0d", i), 64'(bus.in_ready), 64'd1);
            adv();
        end
        bus.in_flit = f3[4];
        mid();
        check("t3_full_ready", 64'(bus.in_ready),     64'd0);
        check("t3_full_req",   64'(bus.buffer_req),   64'd1);
        check("t3_dport",      64'(bus.buffer_dport), 64'd4);
        check("t3_nogrant",    64'(bus.out_fire),     64'd0);
        adv();
        bus.buffer_grant = 1'b1;
        mid();
        check("t3_full_ready2", 64'(bus.in_ready), 64'd0);
        check("t3_full_fire",   64'(bus.out_fire), 64'd1);
        check("t3_full_flit",   64'(bus.out_flit), 64'(f3[0]));
        adv();
        bus.in_valid     = 1'b0;
        bus.buffer_grant = 1'b0;
        mid();
        check("t3_ready_after_pop", 64'(bus.in_ready), 64'd1);
        adv();
        bus.buffer_grant = 1'b1;
        for (int i = 1; i < 4; i++) begin
            mid();
            check($sformatf("t3_drain_fire_%0d", i), 64'(bus.out_fire), 64'd1);
            check($sformatf("t3_drain_flit_%0d", i), 64'(bus.out_flit), 64'(f3[i]));
            adv();
        end
        bus.buffer_grant = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_flit      = f3[4];
        mid();
        check("t3_empty_req",   64'(bus.buffer_req),   64'd0);
        check("t3_empty_dport", 64'(bus.buffer_dport), 64'd4);
        adv();
        bus.in_valid     = 1'b0;
        bus.buffer_grant = 1'b1;
        mid();
        check("t3_tail_fire", 64'(bus.out_fire), 64'd1);
        check("t3_tail_flit", 64'(bus.out_flit), 64'(f3[4]));
        adv();
        bus.buffer_grant = 1'b0;
        mid();
        check("t3_idle_req", 64'(bus.buffer_req), 64'd0);
        adv();

        // Wormhole to (1,2): NORTH, grant toggled, two empty cycles mid-packet.
        f4[0] = mk(T_HEAD, 8'd20, 2'd1, 2'd2);
        f4[1] = mk(T_BODY, 8'd21, 2'd0, 2'd0);
        f4[2] = mk(T_BODY, 8'd22, 2'd0, 2'd0);
        f4[3] = mk(T_TAIL, 8'd23, 2'd0, 2'd0);
        bus.in_valid = 1'b1;
        bus.in_flit  = f4[0];
        adv();
        bus.in_flit  = f4[1];
        mid();
        check("t4_c1_req", 64'(bus.buffer_req), 64'd0);
        adv();
        bus.in_valid     = 1'b0;
        bus.buffer_grant = 1'b1;
        mid();
        check("t4_c2_fire",  64'(bus.out_fire),     64'd1);
        check("t4_c2_flit",  64'(bus.out_flit),     64'(f4[0]));
        check("t4_c2_dport", 64'(bus.buffer_dport), 64'd1);
        adv();
        bus.buffer_grant = 1'b0;
        mid();
        check("t4_c3_req",  64'(bus.buffer_req), 64'd1);
        check("t4_c3_fire", 64'(bus.out_fire),   64'd0);
        adv();
        bus.buffer_grant = 1'b1;
        mid();
        check("t4_c4_fire", 64'(bus.out_fire), 64'd1);
        check("t4_c4_flit", 64'(bus.out_flit), 64'(f4[1]));
        adv();
        mid();
        check("t4_gap1_req",   64'(bus.buffer_req),   64'd0);
        check("t4_gap1_dport", 64'(bus.buffer_dport), 64'd1);
        adv();
        bus.in_valid = 1'b1;
        bus.in_flit  = f4[2];
        mid();
        check("t4_gap2_req", 64'(bus.buffer_req), 64'd0);
        adv();
        bus.in_flit = f4[3];
        mid();
        check("t4_c7_req",  64'(bus.buffer_req), 64'd1);
        check("t4_c7_flit", 64'(bus.out_flit),   64'(f4[2]));
        check("t4_c7_fire", 64'(bus.out_fire),   64'd1);
        adv();
        bus.in_valid = 1'b0;
        mid();
        check("t4_c8_fire",  64'(bus.out_fire),     64'd1);
        check("t4_c8_flit",  64'(bus.out_flit),     64'(f4[3]));
        check("t4_c8_dport", 64'(bus.buffer_dport), 64'd1);
        adv();
        bus.buffer_grant = 1'b0;
        mid();
        check("t4_idle_req", 64'(bus.buffer_req), 64'd0);
        adv();

        // Orphan BODY: dropped, err pulses once, req never raised.
        bus.in_valid = 1'b1;
        bus.in_flit  = mk(T_BODY, 8'd30, 2'd0, 2'd0);
        bus.buffer_grant = 1'b1;
        adv();
        bus.in_valid = 1'b0;
        mid();
        check("t5_err0", 64'(bus.err),        64'd0);
        check("t5_req0", 64'(bus.buffer_req), 64'd0);
        adv();
        mid();
        check("t5_err1",   64'(bus.err),        64'd1);
        check("t5_req1",   64'(bus.buffer_req), 64'd0);
        check("t5_fire1",  64'(bus.out_fire),   64'd0);
        adv();
        mid();
        check("t5_err2", 64'(bus.err),        64'd0);
        check("t5_req2", 64'(bus.buffer_req), 64'd0);
        adv();
        bus.buffer_grant = 1'b0;

        // Reset mid-packet with three flits stored, then SINGLE to (1,1) routes LOCAL.
        bus.in_valid = 1'b1;
        bus.in_flit  = mk(T_HEAD, 8'd40, 2'd2, 2'd1);
        adv();
        bus.in_flit  = mk(T_BODY, 8'd41, 2'd0, 2'd0);
        adv();
        bus.in_flit  = mk(T_BODY, 8'd42, 2'd0, 2'd0);
        adv();
        bus.in_valid = 1'b0;
        mid();
        check("t6_pre_req",   64'(bus.buffer_req),   64'd1);
        check("t6_pre_dport", 64'(bus.buffer_dport), 64'd2);
        rst = 1'b0;
        #1;
        check("t6_rst_req",   64'(bus.buffer_req),   64'd0);
        check("t6_rst_dport", 64'(bus.buffer_dport), 64'd0);
        check("t6_rst_ready", 64'(bus.in_ready),     64'd1);
        @(negedge clk);
        rst = 1'b1;
        adv();
        s50 = mk(T_SINGLE, 8'd50, 2'd1, 2'd1);
        bus.in_valid = 1'b1;
        bus.in_flit  = s50;
        mid();
        check("t6_push_req", 64'(bus.buffer_req), 64'd0);
        adv();
        bus.in_valid = 1'b0;
        mid();
        check("t6_head_req",  64'(bus.buffer_req), 64'd0);
        check("t6_head_flit", 64'(bus.out_flit),   64'(s50));
        adv();
        bus.buffer_grant = 1'b1;
        mid();
        check("t6_req",   64'(bus.buffer_req),   64'd1);
        check("t6_dport", 64'(bus.buffer_dport), 64'd0);
        check("t6_fire",  64'(bus.out_fire),     64'd1);
        adv();
        bus.buffer_grant = 1'b0;
        mid();
        check("t6_idle_req", 64'(bus.buffer_req), 64'd0);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
